// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants, opcodes and instruction field helpers
package cpu_pkg;
    localparam int DATA_W = 16;
    localparam int NREGS  = 8;
    localparam int IMM_W  = 7;
    localparam int RA_W   = 3;

    localparam int OP_LSB = 13;
    localparam int RD_LSB = 10;
    localparam int RS_LSB = 7;
    localparam int RT_LSB = 4;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_ADD  = 3'b001,
        OP_ADDI = 3'b010,
        OP_SUB  = 3'b011,
        OP_SUBI = 3'b100,
        OP_MUL  = 3'b101,
        OP_RSV6 = 3'b110,
        OP_RSV7 = 3'b111
    } opcode_t;

    // Every real ALU operation reads rs; reserved codes behave as NOP.
    function automatic logic op_reads_rs(input opcode_t op);
        return (op == OP_ADD) || (op == OP_ADDI) || (op == OP_SUB) ||
               (op == OP_SUBI) || (op == OP_MUL);
    endfunction

    function automatic logic op_reads_rt(input opcode_t op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
    endfunction

    function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction
endpackage

// File: rtl/module_regfile.sv
// rtl/module_regfile.sv - 8x16 register file, two read ports plus debug, r0 hardwired zero
module module_regfile
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [RA_W-1:0]   i_addr_a,
    input  logic [RA_W-1:0]   i_addr_b,
    input  logic [RA_W-1:0]   i_dbg_addr,
    output logic [DATA_W-1:0] o_data_a,
    output logic [DATA_W-1:0] o_data_b,
    output logic [DATA_W-1:0] o_dbg_data,
    input  logic              i_we,
    input  logic [RA_W-1:0]   i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data
);
    logic [DATA_W-1:0] r_mem [NREGS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
        end else if (i_we && (i_wr_addr != '0)) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_data_a   = (i_addr_a   == '0) ? '0 : r_mem[i_addr_a];
    assign o_data_b   = (i_addr_b   == '0) ? '0 : r_mem[i_addr_b];
    assign o_dbg_data = (i_dbg_addr == '0) ? '0 : r_mem[i_dbg_addr];
endmodule

// File: rtl/module_decode.sv
// rtl/module_decode.sv - decode/register-file stage with forwarding and load-use style interlock
module module_decode
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [15:0]       instr,
    output logic              instr_ready,
    output logic [2:0]        alu_opcode,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    output logic              wb_valid,
    output logic [RA_W-1:0]   wb_rd,
    input  logic [RA_W-1:0]   dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    opcode_t            w_op;
    logic [RA_W-1:0]    w_rd, w_rs, w_rt;
    logic [IMM_W-1:0]   w_imm;
    logic               w_reads_rs, w_reads_rt;
    logic               w_hazard, w_issue, w_we;
    logic [DATA_W-1:0]  w_rf_a, w_rf_b, w_opnd_a, w_opnd_b;

    logic [2:0]         r_alu_op;
    logic [DATA_W-1:0]  r_alu_a, r_alu_b;
    logic               r_ex_we, r_wb_valid;
    logic [RA_W-1:0]    r_ex_rd, r_wb_rd;

    assign w_op  = opcode_t'(instr[OP_LSB +: 3]);
    assign w_rd  = instr[RD_LSB +: RA_W];
    assign w_rs  = instr[RS_LSB +: RA_W];
    assign w_rt  = instr[RT_LSB +: RA_W];
    assign w_imm = instr[IMM_W-1:0];

    assign w_reads_rs = op_reads_rs(w_op);
    assign w_reads_rt = op_reads_rt(w_op);

    // The instruction in EX has no result yet; a reader one slot behind must wait.
    assign w_hazard = instr_valid && r_ex_we && (r_ex_rd != '0) &&
                      ((w_reads_rs && (w_rs == r_ex_rd)) ||
                       (w_reads_rt && (w_rt == r_ex_rd)));
    assign instr_ready = !w_hazard;
    assign w_issue     = instr_valid && !w_hazard && w_reads_rs;
    assign w_we        = w_issue && (w_rd != '0);

    module_regfile u_regfile (
        .clk        (clk),
        .rst        (rst),
        .i_addr_a   (w_rs),
        .i_addr_b   (w_rt),
        .i_dbg_addr (dbg_addr),
        .o_data_a   (w_rf_a),
        .o_data_b   (w_rf_b),
        .o_dbg_data (dbg_data),
        .i_we       (r_wb_valid),
        .i_wr_addr  (r_wb_rd),
        .i_wr_data  (alu_result)
    );

    // WB result bypasses the regfile, which only updates at the coming edge.
    assign w_opnd_a = (r_wb_valid && (w_rs != '0) && (w_rs == r_wb_rd)) ? alu_result : w_rf_a;
    assign w_opnd_b = !w_reads_rt ? sext_imm(w_imm) :
                      (r_wb_valid && (w_rt != '0) && (w_rt == r_wb_rd)) ? alu_result : w_rf_b;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_alu_op   <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_ex_we    <= 1'b0;
            r_ex_rd    <= '0;
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
        end else begin
            if (w_issue) begin
                r_alu_op <= w_op;
                r_alu_a  <= w_opnd_a;
                r_alu_b  <= w_opnd_b;
                r_ex_we  <= w_we;
                r_ex_rd  <= w_rd;
            end else begin
                r_alu_op <= OP_NOP;
                r_alu_a  <= '0;
                r_alu_b  <= '0;
                r_ex_we  <= 1'b0;
                r_ex_rd  <= '0;
            end
            r_wb_valid <= r_ex_we;
            r_wb_rd    <= r_ex_rd;
        end
    end

    assign alu_opcode = r_alu_op;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign wb_valid   = r_wb_valid;
    assign wb_rd      = r_wb_rd;
endmodule
